// File: rtl/candidate_packer.sv
// Packs a (distance, index) candidate stream into 8-lane groups for the bitonic top-4 sorter.
// Define PACKER_PERF_EN to add the saturating stall_cycles counter output.
module candidate_packer #(
    parameter int DATA_W = 25,
    parameter int IDX_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_last,
    input  logic              out_stall,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic [DATA_W-1:0] data_out_3,
    output logic [DATA_W-1:0] data_out_4,
    output logic [DATA_W-1:0] data_out_5,
    output logic [DATA_W-1:0] data_out_6,
    output logic [DATA_W-1:0] data_out_7,
    output logic [IDX_W-1:0]  idx_out_0,
    output logic [IDX_W-1:0]  idx_out_1,
    output logic [IDX_W-1:0]  idx_out_2,
    output logic [IDX_W-1:0]  idx_out_3,
    output logic [IDX_W-1:0]  idx_out_4,
    output logic [IDX_W-1:0]  idx_out_5,
    output logic [IDX_W-1:0]  idx_out_6,
    output logic [IDX_W-1:0]  idx_out_7,
`ifdef PACKER_PERF_EN
    output logic [15:0]       stall_cycles,
`endif
    output logic              last_out
);

    localparam logic [DATA_W-1:0] PAD_DATA = '1;
    localparam logic [IDX_W-1:0]  PAD_IDX  = '1;

    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_data_q [7];
    logic [DATA_W-1:0] fill_data_d [7];
    logic [IDX_W-1:0]  fill_idx_q  [7];
    logic [IDX_W-1:0]  fill_idx_d  [7];
    logic [DATA_W-1:0] lane_data_q [8];
    logic [DATA_W-1:0] lane_data_d [8];
    logic [IDX_W-1:0]  lane_idx_q  [8];
    logic [IDX_W-1:0]  lane_idx_d  [8];
    logic              valid_out_q, valid_out_d;
    logic              last_out_q, last_out_d;
    logic              accept, complete, transfer;

    // The fill buffer only ever holds lanes 0..6; lane 7 always comes straight from the completing beat.
    always_comb begin
        in_ready    = !(valid_out_q && out_stall);
        accept      = in_valid && in_ready;
        complete    = accept && ((cnt_q == 3'd7) || in_last);
        transfer    = valid_out_q && !out_stall;
        cnt_d       = cnt_q;
        fill_data_d = fill_data_q;
        fill_idx_d  = fill_idx_q;
        lane_data_d = lane_data_q;
        lane_idx_d  = lane_idx_q;
        valid_out_d = valid_out_q;
        last_out_d  = last_out_q;

        if (complete) begin
            for (int i = 0; i < 7; i++) begin
                if (i < int'(cnt_q)) begin
                    lane_data_d[i] = fill_data_q[i];
                    lane_idx_d[i]  = fill_idx_q[i];
                end else if (i == int'(cnt_q)) begin
                    lane_data_d[i] = in_data;
                    lane_idx_d[i]  = in_idx;
                end else begin
                    lane_data_d[i] = PAD_DATA;
                    lane_idx_d[i]  = PAD_IDX;
                end
            end
            lane_data_d[7] = (cnt_q == 3'd7) ? in_data : PAD_DATA;
            lane_idx_d[7]  = (cnt_q == 3'd7) ? in_idx  : PAD_IDX;
            last_out_d     = in_last;
            valid_out_d    = 1'b1;
            cnt_d          = 3'd0;
        end else begin
            if (accept) begin
                fill_data_d[cnt_q] = in_data;
                fill_idx_d[cnt_q]  = in_idx;
                cnt_d              = cnt_q + 3'd1;
            end
            if (transfer) begin
                valid_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= 3'd0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                lane_data_q[i] <= '0;
                lane_idx_q[i]  <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
            lane_data_q <= lane_data_d;
            lane_idx_q  <= lane_idx_d;
        end
    end

    // Fill contents are don't-care until written, so they need no reset.
    always_ff @(posedge clk) begin
        fill_data_q <= fill_data_d;
        fill_idx_q  <= fill_idx_d;
    end

`ifdef PACKER_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (valid_out_q && out_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

    assign valid_out  = valid_out_q;
    assign last_out   = last_out_q;
    assign data_out_0 = lane_data_q[0];
    assign data_out_1 = lane_data_q[1];
    assign data_out_2 = lane_data_q[2];
    assign data_out_3 = lane_data_q[3];
    assign data_out_4 = lane_data_q[4];
    assign data_out_5 = lane_data_q[5];
    assign data_out_6 = lane_data_q[6];
    assign data_out_7 = lane_data_q[7];
    assign idx_out_0  = lane_idx_q[0];
    assign idx_out_1  = lane_idx_q[1];
    assign idx_out_2  = lane_idx_q[2];
    assign idx_out_3  = lane_idx_q[3];
    assign idx_out_4  = lane_idx_q[4];
    assign idx_out_5  = lane_idx_q[5];
    assign idx_out_6  = lane_idx_q[6];
    assign idx_out_7  = lane_idx_q[7];

endmodule

// File: tb/tb_candidate_packer.sv
// Self-checking bench for candidate_packer: directed scenarios followed by random traffic,
// all compared against a queue-based model of how beats become padded 8-lane groups.
module tb_candidate_packer;

    localparam int DATA_W = 25;
    localparam int IDX_W  = 15;
    localparam logic [DATA_W-1:0] PAD_D = '1;
    localparam logic [IDX_W-1:0]  PAD_I = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  in_idx;
    logic              in_last;
    logic              out_stall;
    logic              valid_out;
    logic              last_out;
    logic [DATA_W-1:0] dout [8];
    logic [IDX_W-1:0]  iout [8];
`ifdef PACKER_PERF_EN
    logic [15:0]       stall_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: beats of the group being collected, and the group the outputs should show.
    logic [DATA_W-1:0] cur_d [$];
    logic [IDX_W-1:0]  cur_i [$];
    logic [DATA_W-1:0] exp_d [8];
    logic [IDX_W-1:0]  exp_i [8];
    bit                exp_last;
    bit                exp_valid;
    int                exp_stall;

    candidate_packer #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_idx(in_idx), .in_last(in_last),
        .out_stall(out_stall), .valid_out(valid_out),
        .data_out_0(dout[0]), .data_out_1(dout[1]), .data_out_2(dout[2]), .data_out_3(dout[3]),
        .data_out_4(dout[4]), .data_out_5(dout[5]), .data_out_6(dout[6]), .data_out_7(dout[7]),
        .idx_out_0(iout[0]), .idx_out_1(iout[1]), .idx_out_2(iout[2]), .idx_out_3(iout[3]),
        .idx_out_4(iout[4]), .idx_out_5(iout[5]), .idx_out_6(iout[6]), .idx_out_7(iout[7]),
`ifdef PACKER_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .last_out(last_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkState();
        checkOutput("valid_out", 64'(valid_out), 64'(exp_valid));
        checkOutput("last_out", 64'(last_out), 64'(exp_last));
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("data_out_%0d", k), 64'(dout[k]), 64'(exp_d[k]));
            checkOutput($sformatf("idx_out_%0d", k), 64'(iout[k]), 64'(exp_i[k]));
        end
`ifdef PACKER_PERF_EN
        checkOutput("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
`endif
    endtask

    task automatic modelReset();
        cur_d.delete();
        cur_i.delete();
        for (int k = 0; k < 8; k++) begin
            exp_d[k] = '0;
            exp_i[k] = '0;
        end
        exp_last  = 1'b0;
        exp_valid = 1'b0;
        exp_stall = 0;
    endtask

    task automatic doReset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        in_idx    = '0;
        out_stall = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        checkState();
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model, then check registered outputs.
    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i,
                                 input bit l, input bit stall, output bit accepted);
        bit m_ready;
        in_valid  = v;
        in_data   = d;
        in_idx    = i;
        in_last   = l;
        out_stall = stall;
        #1;
        m_ready = !(exp_valid && stall);
        checkOutput("in_ready", 64'(in_ready), 64'(m_ready));
        accepted = v && m_ready;
        if (exp_valid && stall && exp_stall < 65535) exp_stall++;
        if (exp_valid && !stall) exp_valid = 1'b0;
        if (accepted) begin
            cur_d.push_back(d);
            cur_i.push_back(i);
            if (cur_d.size() == 8 || l) begin
                for (int k = 0; k < 8; k++) begin
                    exp_d[k] = (k < cur_d.size()) ? cur_d[k] : PAD_D;
                    exp_i[k] = (k < cur_i.size()) ? cur_i[k] : PAD_I;
                end
                exp_last  = l;
                exp_valid = 1'b1;
                cur_d.delete();
                cur_i.delete();
            end
        end
        @(posedge clk);
        #1;
        checkState();
    endtask

    task automatic sendBeat(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i, input bit l);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, d, i, l, 1'b0, acc);
            tries++;
        end
        if (!acc) checkOutput("send_beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        bit have;
        bit rl;
        bit st;
        logic [DATA_W-1:0] rd;
        logic [IDX_W-1:0]  ri;

        doReset(2);

        $display("[TB] full group data 10..17, last on beat 8");
        for (int k = 0; k < 8; k++) sendBeat(DATA_W'(10 + k), IDX_W'(k), k == 7);
        checkOutput("full_lane7_data", 64'(dout[7]), 64'd17);
        checkOutput("full_last", 64'(last_out), 64'd1);
        idle(2);

        $display("[TB] short group 5,3,9 padded");
        sendBeat(DATA_W'(5), IDX_W'(1), 1'b0);
        sendBeat(DATA_W'(3), IDX_W'(2), 1'b0);
        sendBeat(DATA_W'(9), IDX_W'(3), 1'b1);
        checkOutput("short_lane3_pad", 64'(dout[3]), 64'h1FFFFFF);
        checkOutput("short_lane7_idx_pad", 64'(iout[7]), 64'h7FFF);
        idle(1);

        $display("[TB] stall for three cycles with a beat waiting");
        doReset(1);
        for (int k = 0; k < 8; k++) sendBeat(DATA_W'(20 + k), IDX_W'(k + 8), k == 7);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, DATA_W'(50), IDX_W'(9), 1'b1, 1'b1, acc);
            checkOutput("stalled_beat_held_off", 64'(acc), 64'd0);
        end
        applyStimulus(1'b1, DATA_W'(50), IDX_W'(9), 1'b1, 1'b0, acc);
        checkOutput("beat_taken_after_stall", 64'(acc), 64'd1);
`ifdef PACKER_PERF_EN
        checkOutput("stall_count_three", 64'(stall_cycles), 64'd3);
`endif
        idle(2);

        $display("[TB] sixteen back-to-back beats");
        for (int k = 0; k < 16; k++) sendBeat(DATA_W'(200 + k), IDX_W'(300 + k), k == 15);
        idle(2);

        $display("[TB] reset mid-group then fresh group 100..107");
        for (int k = 0; k < 5; k++) sendBeat(DATA_W'(60 + k), IDX_W'(k), 1'b0);
        doReset(1);
        for (int k = 0; k < 8; k++) sendBeat(DATA_W'(100 + k), IDX_W'(k), k == 7);
        checkOutput("fresh_lane0", 64'(dout[0]), 64'd100);
        idle(1);

        $display("[TB] single-beat query");
        sendBeat(DATA_W'(42), IDX_W'(7), 1'b1);
        checkOutput("single_idx0", 64'(iout[0]), 64'd7);
        checkOutput("single_lane1_pad", 64'(dout[1]), 64'h1FFFFFF);
        idle(2);

        $display("[TB] random traffic");
        have = 1'b0;
        rd = '0;
        ri = '0;
        rl = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!have && $urandom_range(3) != 0) begin
                rd   = DATA_W'($urandom);
                ri   = IDX_W'($urandom);
                rl   = ($urandom_range(5) == 0);
                have = 1'b1;
            end
            st = ($urandom_range(3) == 0);
            applyStimulus(have, rd, ri, rl, st, acc);
            if (acc) have = 1'b0;
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
